// File: rtl/seq_divider.sv
// Sequential restoring divider: 2N-bit dividend / N-bit divisor, one quotient bit per clock.
// Optional macro SEQ_DIVIDER_ZERO_FAST_EN: a zero divisor skips the BUSY schedule.
module seq_divider #(
    parameter int unsigned N = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2*N-1:0]   dividend,
    input  logic [N-1:0]     divisor,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [2*N-1:0]   quotient,
    output logic [N-1:0]     remainder,
    output logic             div_by_zero
);

    localparam int unsigned CW = $clog2(2*N+1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t           state_q;
    logic [N-1:0]     prem_q;
    logic [2*N-1:0]   shreg_q;
    logic [N-1:0]     dvsr_q;
    logic [CW-1:0]    cnt_q;
    logic             busy_q;
    logic             done_q;
    logic             dbz_q;
    logic [2*N-1:0]   quot_q;
    logic [N-1:0]     rem_q;

    logic [N:0]       shifted_d;
    logic [N:0]       trial_d;
    logic             qbit_d;
    logic [N-1:0]     prem_d;
    logic [2*N-1:0]   shreg_d;

    // The stored partial remainder is always below the divisor, so N bits hold it;
    // only the shifted value needs the extra bit for the trial subtraction.
    always_comb begin
        shifted_d = {prem_q, shreg_q[2*N-1]};
        trial_d   = shifted_d - {1'b0, dvsr_q};
        qbit_d    = ~trial_d[N];
        prem_d    = qbit_d ? trial_d[N-1:0] : shifted_d[N-1:0];
        shreg_d   = {shreg_q[2*N-2:0], qbit_d};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            prem_q  <= '0;
            shreg_q <= '0;
            dvsr_q  <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
            quot_q  <= '0;
            rem_q   <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        dvsr_q  <= divisor;
                        shreg_q <= dividend;
                        prem_q  <= '0;
                        cnt_q   <= CW'(2*N);
                        quot_q  <= '0;
                        rem_q   <= '0;
                        dbz_q   <= 1'b0;
`ifdef SEQ_DIVIDER_ZERO_FAST_EN
                        if (divisor == '0) begin
                            state_q <= DONE;
                        end else begin
                            busy_q  <= 1'b1;
                            state_q <= BUSY;
                        end
`else
                        busy_q  <= 1'b1;
                        state_q <= BUSY;
`endif
                    end
                end
                BUSY: begin
                    prem_q  <= prem_d;
                    shreg_q <= shreg_d;
                    cnt_q   <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                        if (dvsr_q == '0) begin
                            quot_q <= '1;
                            rem_q  <= '0;
                            dbz_q  <= 1'b1;
                        end else begin
                            quot_q <= shreg_d;
                            rem_q  <= prem_d;
                        end
                    end
                end
                DONE: begin
`ifdef SEQ_DIVIDER_ZERO_FAST_EN
                    // Fast zero path enters DONE with done low; raise it one edge later.
                    if (!done_q) begin
                        done_q <= 1'b1;
                        quot_q <= '1;
                        rem_q  <= '0;
                        dbz_q  <= 1'b1;
                    end else begin
                        done_q  <= 1'b0;
                        state_q <= IDLE;
                    end
`else
                    done_q  <= 1'b0;
                    state_q <= IDLE;
`endif
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quot_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider: latency, back-to-back starts, zero divisor, reset abort.
module tb_seq_divider;

    localparam int unsigned N = 3;

    logic           clk;
    logic           rst;
    logic [2*N-1:0] dividend;
    logic [N-1:0]   divisor;
    logic           start;
    logic           busy;
    logic           done;
    logic [2*N-1:0] quotient;
    logic [N-1:0]   remainder;
    logic           div_by_zero;

    int total;
    int bad;

    seq_divider #(.N(N)) dut (
        .clk         (clk),
        .rst         (rst),
        .dividend    (dividend),
        .divisor     (divisor),
        .start       (start),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef SEQ_DIVIDER_ZERO_FAST_EN
    localparam int ZERO_CYC  = 1;
    localparam int ZERO_BUSY = 0;
`else
    localparam int ZERO_CYC  = 6;
    localparam int ZERO_BUSY = 6;
`endif

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [2*N-1:0] dd, input logic [N-1:0] dv);
        dividend = dd;
        divisor  = dv;
        start    = 1'b1;
        step();
        start    = 1'b0;
    endtask

    task automatic wait_done(output int cyc, output int bc);
        cyc = 0;
        bc  = 0;
        while (done !== 1'b1 && cyc < 20) begin
            if (busy === 1'b1) bc++;
            step();
            cyc++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
        #1;
        total++; if ({busy, done, div_by_zero} !== 3'b000) begin bad++; $display("FAIL reset_flags: got %b expected 000", {busy, done, div_by_zero}); end
        total++; if (quotient !== 6'd0) begin bad++; $display("FAIL reset_quot: got %0d expected 0", quotient); end
        total++; if (remainder !== 3'd0) begin bad++; $display("FAIL reset_rem: got %0d expected 0", remainder); end
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic test_basic();
        int cyc, bc;
        do_start(6'd63, 3'd7);
        wait_done(cyc, bc);
        total++; if (cyc != 6) begin bad++; $display("FAIL basic_latency: got %0d expected 6", cyc); end
        total++; if (bc != 6) begin bad++; $display("FAIL basic_busy_cycles: got %0d expected 6", bc); end
        total++; if (quotient !== 6'd9) begin bad++; $display("FAIL basic_quot: got %0d expected 9", quotient); end
        total++; if (remainder !== 3'd0) begin bad++; $display("FAIL basic_rem: got %0d expected 0", remainder); end
        total++; if (div_by_zero !== 1'b0) begin bad++; $display("FAIL basic_dbz: got %b expected 0", div_by_zero); end
        step();
        total++; if ({busy, done} !== 2'b00) begin bad++; $display("FAIL basic_done_pulse: got busy,done=%b expected 00", {busy, done}); end
        step();
    endtask

    task automatic test_back_to_back();
        int cyc, bc;
        do_start(6'd45, 3'd5);
        wait_done(cyc, bc);
        total++; if (cyc != 6) begin bad++; $display("FAIL b2b_first_latency: got %0d expected 6", cyc); end
        total++; if (quotient !== 6'd9 || remainder !== 3'd0) begin bad++; $display("FAIL b2b_first: got q=%0d r=%0d expected q=9 r=0", quotient, remainder); end
        dividend = 6'd45; divisor = 3'd7; start = 1'b1;
        step();
        total++; if (busy !== 1'b0 || quotient !== 6'd9) begin bad++; $display("FAIL b2b_start_in_done: got busy=%b q=%0d expected busy=0 q=9", busy, quotient); end
        step();
        start = 1'b0;
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL b2b_accept_idle: got busy=%b expected 1", busy); end
        wait_done(cyc, bc);
        total++; if (cyc != 6) begin bad++; $display("FAIL b2b_second_latency: got %0d expected 6", cyc); end
        total++; if (quotient !== 6'd6 || remainder !== 3'd3) begin bad++; $display("FAIL b2b_second: got q=%0d r=%0d expected q=6 r=3", quotient, remainder); end
        step();
    endtask

    task automatic test_div_zero();
        int cyc, bc;
        do_start(6'd20, 3'd0);
        wait_done(cyc, bc);
        total++; if (cyc != ZERO_CYC) begin bad++; $display("FAIL zero_latency: got %0d expected %0d", cyc, ZERO_CYC); end
        total++; if (bc != ZERO_BUSY) begin bad++; $display("FAIL zero_busy_cycles: got %0d expected %0d", bc, ZERO_BUSY); end
        total++; if (quotient !== 6'd63 || remainder !== 3'd0) begin bad++; $display("FAIL zero_result: got q=%0d r=%0d expected q=63 r=0", quotient, remainder); end
        total++; if (div_by_zero !== 1'b1) begin bad++; $display("FAIL zero_flag: got %b expected 1", div_by_zero); end
        step();
        total++; if (done !== 1'b0 || div_by_zero !== 1'b1) begin bad++; $display("FAIL zero_hold: got done=%b dbz=%b expected done=0 dbz=1", done, div_by_zero); end
        step();
    endtask

    task automatic test_small_results();
        int cyc, bc;
        do_start(6'd5, 3'd6);
        wait_done(cyc, bc);
        total++; if (quotient !== 6'd0 || remainder !== 3'd5) begin bad++; $display("FAIL small_5_6: got q=%0d r=%0d expected q=0 r=5", quotient, remainder); end
        total++; if (div_by_zero !== 1'b0) begin bad++; $display("FAIL small_dbz_clear: got %b expected 0", div_by_zero); end
        step();
        step();
        do_start(6'd4, 3'd1);
        wait_done(cyc, bc);
        total++; if (quotient !== 6'd4 || remainder !== 3'd0) begin bad++; $display("FAIL small_4_1: got q=%0d r=%0d expected q=4 r=0", quotient, remainder); end
        dividend = 6'd33; divisor = 3'd2;
        for (int i = 0; i < 100; i++) begin
            step();
            total++; if (quotient !== 6'd4 || remainder !== 3'd0 || done !== 1'b0) begin bad++; $display("FAIL hold_cycle_%0d: got q=%0d r=%0d done=%b expected q=4 r=0 done=0", i, quotient, remainder, done); end
        end
    endtask

    task automatic test_start_mid_busy();
        int cyc, bc;
        do_start(6'd49, 3'd7);
        step();
        dividend = 6'd10; divisor = 3'd3; start = 1'b1;
        step();
        start = 1'b0;
        wait_done(cyc, bc);
        total++; if (cyc != 4) begin bad++; $display("FAIL midbusy_latency: got %0d remaining expected 4", cyc); end
        total++; if (quotient !== 6'd7 || remainder !== 3'd0) begin bad++; $display("FAIL midbusy_result: got q=%0d r=%0d expected q=7 r=0", quotient, remainder); end
        step();
        step();
    endtask

    task automatic test_reset_mid_op();
        int cyc, bc;
        int seen;
        do_start(6'd63, 3'd7);
        step();
        step();
        rst = 1'b1;
        #1;
        total++; if ({busy, done, div_by_zero} !== 3'b000) begin bad++; $display("FAIL rstmid_flags: got %b expected 000", {busy, done, div_by_zero}); end
        total++; if (quotient !== 6'd0 || remainder !== 3'd0) begin bad++; $display("FAIL rstmid_result: got q=%0d r=%0d expected q=0 r=0", quotient, remainder); end
        step();
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (done === 1'b1 || busy === 1'b1) seen++;
        end
        total++; if (seen != 0) begin bad++; $display("FAIL rstmid_no_done: got %0d active cycles expected 0", seen); end
        do_start(6'd36, 3'd6);
        wait_done(cyc, bc);
        total++; if (cyc != 6) begin bad++; $display("FAIL rstmid_new_latency: got %0d expected 6", cyc); end
        total++; if (quotient !== 6'd6 || remainder !== 3'd0) begin bad++; $display("FAIL rstmid_new_result: got q=%0d r=%0d expected q=6 r=0", quotient, remainder); end
        step();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_div_zero();
        test_small_results();
        test_start_mid_busy();
        test_reset_mid_op();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
